// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl : single-outstanding instruction fetch sequencer with
//                 stall hold, redirect and misaligned-target trapping.
// Revision      : 1.0
// ============================================================================
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc4,
   output logic        misalign_trap
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_OUT   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] r_instr_pc4;
   logic        r_instr_valid;
   logic        r_misalign_trap;
   logic        w_capture;
   logic        w_release;
   logic        w_misalign;
   logic [31:0] w_redir_pc;
   logic [31:0] w_pc_plus4;

   assign w_misalign = (redirect_target[1:0] != 2'b00);
   assign w_redir_pc = w_misalign ? TRAP_VEC : redirect_target;
   assign w_pc_plus4 = r_pc + 32'd4;

   // Redirect outranks every handshake; an accepted-but-unanswered request
   // must still be drained so only one request is ever in flight.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = S_REQ;
         S_REQ: begin
            if (redirect_valid)
               w_state_nxt = imem_gnt ? S_DRAIN : S_REQ;
            else if (imem_gnt)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
            end else if (imem_rvalid) begin
               w_state_nxt = S_OUT;
               w_capture   = 1'b1;
            end
         end
         S_OUT: begin
            if (redirect_valid) begin
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_state_nxt = S_REQ;
               w_release   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (imem_rvalid)
               w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_pc            <= RESET_VEC;
         r_instr         <= 32'd0;
         r_instr_pc      <= 32'd0;
         r_instr_pc4     <= 32'd0;
         r_instr_valid   <= 1'b0;
         r_misalign_trap <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_misalign_trap <= redirect_valid && w_misalign;
         if (redirect_valid) begin
            r_pc          <= w_redir_pc;
            r_instr_valid <= 1'b0;
         end else if (w_capture) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_pc4   <= w_pc_plus4;
            r_pc          <= w_pc_plus4;
            r_instr_valid <= 1'b1;
         end else if (w_release) begin
            r_instr_valid <= 1'b0;
         end
      end
   end

   assign imem_req      = (r_state == S_REQ);
   assign imem_addr     = r_pc;
   assign instr_valid   = r_instr_valid;
   assign instr         = r_instr;
   assign instr_pc      = r_instr_pc;
   assign instr_pc4     = r_instr_pc4;
   assign misalign_trap = r_misalign_trap;

endmodule
`default_nettype wire
